// File: rtl/spi_master_gen_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and parameter range checks.
package spi_master_gen_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        XFER  = 3'd2,
        TRAIL = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_e;

    localparam int DATA_W_MIN  = 2;
    localparam int DATA_W_MAX  = 32;
    localparam int NUM_CS_MIN  = 1;
    localparam int NUM_CS_MAX  = 8;
    localparam int CLK_DIV_MIN = 2;

    function automatic bit params_ok(input int data_w, input int num_cs, input int clk_div);
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
               (num_cs >= NUM_CS_MIN) && (num_cs <= NUM_CS_MAX) &&
               (clk_div >= CLK_DIV_MIN);
    endfunction

    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_gen_tick.sv
// Half-period tick divider: pulses tick once every MOD enabled cycles, restarts whenever disabled.
module spi_master_gen_tick #(
    parameter int MOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(MOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master: per-transfer CPOL/CPHA/bit order, multiple chip selects, CS-hold bursts.
module spi_master_gen
    import spi_master_gen_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 50,
    localparam int CS_W   = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cs_hold,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    if (!params_ok(DATA_W, NUM_CS, CLK_DIV)) begin : g_param_check
        $error("spi_master_gen: DATA_W, NUM_CS or CLK_DIV out of range");
    end

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                   input logic b);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // Out-of-range selects leave every line deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    state_e              state_q, state_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic                sclk_q, sclk_d, mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                rx_valid_q, rx_valid_d, busy_q, busy_d, tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                tick, tick_en, accept;

    assign accept  = tx_valid && tx_ready_q;
    assign tick_en = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL) || (state_q == GAP);

    spi_master_gen_tick #(.MOD(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        hold_d     = hold_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                if (accept) begin
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsb_d      = lsb_first;
                    hold_d     = cs_hold;
                    cs_n_d     = cs_decode(cs_sel);
                    mosi_d     = first_bit(tx_data, lsb_first);
                    tx_sh_d    = cpha ? tx_data : shift_out(tx_data, lsb_first);
                    edge_cnt_d = '0;
                    state_d    = LEAD;
                end
            end
            LEAD: begin
                sclk_d = cpol_q;
                if (tick) state_d = XFER;
            end
            XFER: begin
                // Even edge count means the next edge is a leading one; sample when that matches CPHA.
                if (tick) begin
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q[0] == cpha_q) begin
                        rx_sh_d = shift_in(rx_sh_q, lsb_q, miso);
                    end else if (edge_cnt_q != LAST_EDGE) begin
                        mosi_d  = first_bit(tx_sh_q, lsb_q);
                        tx_sh_d = shift_out(tx_sh_q, lsb_q);
                    end
                    if (edge_cnt_q == LAST_EDGE) begin
                        edge_cnt_d = '0;
                        state_d    = TRAIL;
                    end
                end
            end
            TRAIL: begin
                sclk_d = cpol_q;
                if (tick) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    if (hold_q) begin
                        state_d = HOLD;
                    end else begin
                        cs_n_d  = '1;
                        state_d = GAP;
                    end
                end
            end
            HOLD: begin
                sclk_d = cpol_q;
                if (accept) begin
                    hold_d     = cs_hold;
                    mosi_d     = first_bit(tx_data, lsb_q);
                    tx_sh_d    = cpha_q ? tx_data : shift_out(tx_data, lsb_q);
                    edge_cnt_d = '0;
                    state_d    = LEAD;
                end
            end
            GAP: begin
                sclk_d = cpol;
                cs_n_d = '1;
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tx_ready_d = (state_d == IDLE) || (state_d == HOLD);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            hold_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            hold_q     <= hold_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: an 8-bit/2-CS instance with a slave model and a 16-bit/4-CS loopback instance.
module tb_spi_master_gen;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        tx_valid = 1'b0, tx_ready;
    logic [7:0]  tx_data = '0;
    logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, cs_hold = 1'b0;
    logic [0:0]  cs_sel = '0;
    logic        rx_valid, busy, sclk, mosi, miso;
    logic [7:0]  rx_data;
    logic [1:0]  cs_n;

    logic        tx_valid16 = 1'b0, tx_ready16;
    logic [15:0] tx_data16 = '0;
    logic [1:0]  cs_sel16 = '0;
    logic        rx_valid16, busy16, sclk16, mosi16, miso16;
    logic [15:0] rx_data16;
    logic [3:0]  cs_n16;

    logic        loopback = 1'b1;
    logic        slv_miso = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    assign miso   = loopback ? mosi : slv_miso;
    assign miso16 = mosi16;

    always #5 clk = ~clk;

    spi_master_gen #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel), .cs_hold(cs_hold),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_master_gen #(.DATA_W(16), .NUM_CS(4), .CLK_DIV(CLK_DIV)) dut16 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid16), .tx_ready(tx_ready16), .tx_data(tx_data16),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel16), .cs_hold(cs_hold),
        .rx_valid(rx_valid16), .rx_data(rx_data16), .busy(busy16), .sclk(sclk16), .mosi(mosi16),
        .miso(miso16), .cs_n(cs_n16)
    );

    // Event counters and an 8-bit MSB-first slave, all observed on the falling edge.
    int         sclkEdges16 = 0, cs1Rises = 0, cs0Lows = 0, rxPulses = 0, multiLow = 0;
    logic       prevSclk16 = 1'b0, prevCs1 = 1'b1, prevSclk = 1'b0, prevCsAct = 1'b0;
    logic [7:0] slvWord = '0, slvSh = '0, slvRx = '0;
    logic       slvCpha = 1'b0, slvFirstMosi = 1'b0, slvFirstSeen = 1'b0;
    int         slvN = 0;

    always @(negedge clk) begin
        logic csAct;
        if (sclk16 !== prevSclk16) sclkEdges16++;
        prevSclk16 = sclk16;
        if (cs_n[1] && !prevCs1) cs1Rises++;
        prevCs1 = cs_n[1];
        if (!cs_n[0]) cs0Lows++;
        if (rx_valid) rxPulses++;
        if ($countones(~cs_n) > 1 || $countones(~cs_n16) > 1) multiLow++;
        csAct = (cs_n != 2'b11);
        if (csAct && !prevCsAct) begin
            slvN = 0;
            slvRx = '0;
            slvSh = slvWord;
            slvFirstSeen = 1'b0;
            if (!slvCpha) begin
                slv_miso = slvSh[7];
                slvSh = slvSh << 1;
            end
        end else if (csAct && (sclk !== prevSclk)) begin
            slvN++;
            if (((slvN % 2) == 1) != slvCpha) begin
                if (!slvFirstSeen) begin
                    slvFirstMosi = mosi;
                    slvFirstSeen = 1'b1;
                end
                slvRx = {slvRx[6:0], mosi};
            end else begin
                slv_miso = slvSh[7];
                slvSh = slvSh << 1;
            end
        end
        prevCsAct = csAct;
        prevSclk = sclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic settleCycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic pol, input logic pha,
                                 input logic lsb, input logic sel, input logic hold);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            settleCycle(1);
            n++;
        end
        checkOutput("tx_ready_before_send", 32'(tx_ready), 1);
        tx_data   = data;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        cs_sel    = sel;
        cs_hold   = hold;
        tx_valid  = 1'b1;
        settleCycle(1);
        tx_valid  = 1'b0;
    endtask

    task automatic waitRx(output int lat);
        lat = 0;
        @(negedge clk);
        while (!rx_valid && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("rx_valid_seen", 32'(rx_valid), 1);
    endtask

    task automatic waitReady(output int g);
        g = 0;
        while (!tx_ready && g < 5000) begin
            @(negedge clk);
            g++;
        end
    endtask

    initial begin
        int lat, g, r0, c1, c0, e0, lat16;
        logic [7:0] modeData [4];
        logic [7:0] burstData [3];
        logic [3:0] csMid;
        modeData  = '{8'h96, 8'h4B, 8'hD2, 8'h17};
        burstData = '{8'hC3, 8'h5E, 8'h81};

        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", 32'(cs_n), 32'h3);
        checkOutput("rst_sclk", 32'(sclk), 0);
        checkOutput("rst_mosi", 32'(mosi), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 0);
        checkOutput("rst_rx_data", 32'(rx_data), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_tx_ready", 32'(tx_ready), 0);
        rst = 1'b0;
        settleCycle(1);
        checkOutput("post_rst_tx_ready", 32'(tx_ready), 1);

        // Mode 0 loopback with latency, CS and gap timing.
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("m0_cs_low", 32'(cs_n), 32'h2);
        checkOutput("m0_busy", 32'(busy), 1);
        waitRx(lat);
        checkOutput("m0_latency", 32'(lat), 32'(CLK_DIV * 18));
        checkOutput("m0_rx_data", 32'(rx_data), 32'hA5);
        checkOutput("m0_cs_release", 32'(cs_n), 32'h3);
        waitReady(g);
        checkOutput("m0_gap", 32'(g), 32'(CLK_DIV));

        // All four modes against a slave returning 0x3C.
        loopback = 1'b0;
        slvWord  = 8'h3C;
        for (int m = 0; m < 4; m++) begin
            cpol    = m[1];
            slvCpha = m[0];
            settleCycle(3);
            checkOutput($sformatf("mode%0d_idle_sclk_pre", m), 32'(sclk), 32'(m[1]));
            applyStimulus(modeData[m], m[1], m[0], 1'b0, 1'b0, 1'b0);
            waitRx(lat);
            checkOutput($sformatf("mode%0d_rx_data", m), 32'(rx_data), 32'h3C);
            waitReady(g);
            checkOutput($sformatf("mode%0d_idle_sclk_post", m), 32'(sclk), 32'(m[1]));
            settleCycle(1);
            checkOutput($sformatf("mode%0d_slave_rx", m), 32'(slvRx), 32'(modeData[m]));
        end

        // LSB-first: slave sends 0x35 MSB-first, master assembles 0xAC.
        cpol    = 1'b0;
        slvCpha = 1'b0;
        slvWord = 8'h35;
        settleCycle(2);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        waitRx(lat);
        checkOutput("lsb_rx_data", 32'(rx_data), 32'hAC);
        waitReady(g);
        settleCycle(1);
        checkOutput("lsb_first_mosi", 32'(slvFirstMosi), 1);
        checkOutput("lsb_slave_rx", 32'(slvRx), 32'h80);

        // Three-word burst on cs_sel=1.
        loopback = 1'b1;
        r0 = rxPulses;
        c1 = cs1Rises;
        c0 = cs0Lows;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(burstData[i], 1'b0, 1'b0, 1'b0, 1'b1, (i < 2) ? 1'b1 : 1'b0);
            waitRx(lat);
            checkOutput($sformatf("burst%0d_latency", i), 32'(lat), 32'(CLK_DIV * 18));
            checkOutput($sformatf("burst%0d_rx_data", i), 32'(rx_data), 32'(burstData[i]));
            checkOutput($sformatf("burst%0d_cs_n", i), 32'(cs_n), (i < 2) ? 32'h1 : 32'h3);
            waitReady(g);
        end
        checkOutput("burst_gap", 32'(g), 32'(CLK_DIV));
        settleCycle(1);
        checkOutput("burst_rx_pulses", 32'(rxPulses - r0), 3);
        checkOutput("burst_cs1_rises", 32'(cs1Rises - c1), 1);
        checkOutput("burst_cs0_lows", 32'(cs0Lows - c0), 0);

        // Reset during the 5th bit of a mode-2 transfer.
        cpol = 1'b1;
        settleCycle(3);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (37) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midrst_cs_n", 32'(cs_n), 32'h3);
        checkOutput("midrst_sclk", 32'(sclk), 0);
        checkOutput("midrst_mosi", 32'(mosi), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_tx_ready", 32'(tx_ready), 0);
        checkOutput("midrst_rx_data", 32'(rx_data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settleCycle(1);
        checkOutput("midrst_release_ready", 32'(tx_ready), 1);
        settleCycle(2);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitRx(lat);
        checkOutput("after_rst_latency", 32'(lat), 32'(CLK_DIV * 18));
        checkOutput("after_rst_rx_data", 32'(rx_data), 32'h5A);
        waitReady(g);

        // 16-bit, 4-CS instance: 0xBEEF to cs_sel=3 in loopback.
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        cs_hold   = 1'b0;
        settleCycle(3);
        checkOutput("w16_tx_ready", 32'(tx_ready16), 1);
        e0 = sclkEdges16;
        tx_data16  = 16'hBEEF;
        cs_sel16   = 2'd3;
        tx_valid16 = 1'b1;
        settleCycle(1);
        tx_valid16 = 1'b0;
        lat16 = 0;
        csMid = '1;
        @(negedge clk);
        while (!rx_valid16 && lat16 < 5000) begin
            if (lat16 == 10) csMid = cs_n16;
            @(negedge clk);
            lat16++;
        end
        checkOutput("w16_rx_valid_seen", 32'(rx_valid16), 1);
        checkOutput("w16_latency", 32'(lat16), 32'(CLK_DIV * 34));
        checkOutput("w16_cs_n_mid", 32'(csMid), 32'h7);
        checkOutput("w16_rx_data", 32'(rx_data16), 32'hBEEF);
        settleCycle(6);
        checkOutput("w16_sclk_edges", 32'(sclkEdges16 - e0), 32);
        checkOutput("w16_cs_release", 32'(cs_n16), 32'hF);

        checkOutput("cs_onehot_violations", 32'(multiLow), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
